// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions for the 1-to-N crossbar path.
//   - TL-UL A/D opcode constants (3-bit encodings)
//   - crossbar FSM state encoding
//   - saturating 8-bit increment used by the error counter
package tlul_pkg;

  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_PUT_FULL_DATA   = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } xbar_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tlul_addr_decode.sv
// Combinational address decoder for the TL-UL 1-to-N crossbar.
//   addr       : request address
//   slave_base : flattened base addresses, slave i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   slave_mask : flattened decode masks, same layout
//   hit        : at least one slave matches
//   idx        : lowest matching slave index (0 when no hit)
module tlul_addr_decode #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] slave_base,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] slave_mask,
  output logic                             hit,
  output logic [IDX_W-1:0]                 idx
);

  logic [NUM_SLAVES-1:0] match;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_match
    assign match[i] = (addr & slave_mask[i*ADDR_WIDTH +: ADDR_WIDTH])
                      == slave_base[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/tlul_xbar_1ton.sv
// TL-UL 1-to-N crossbar, one transaction in flight.
// Routes the master A channel to the slave selected by address decode and
// returns that slave's D response. Unmapped addresses and slave timeouts get
// a locally built error response (counted in err_count, saturating at 255).
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   master_a_*             : TL-UL A channel from the master
//   master_d_*             : TL-UL D channel to the master
//   slave_a_valid/ready    : per-slave A handshake; payload broadcast
//   slave_d_valid/ready    : per-slave D handshake; payload flattened per slave
//   err_count              : locally generated error responses
// Every output comes from a register or from the state/sel registers only.
module tlul_xbar_1ton
  import tlul_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter int SOURCE_WIDTH = 1,
  parameter int NUM_SLAVES   = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               master_a_valid,
  output logic                               master_a_ready,
  input  logic [OPCODE_WIDTH-1:0]            master_a_opcode,
  input  logic [PARAM_WIDTH-1:0]             master_a_param,
  input  logic [SIZE_WIDTH-1:0]              master_a_size,
  input  logic [SOURCE_WIDTH-1:0]            master_a_source,
  input  logic [ADDR_WIDTH-1:0]              master_a_address,
  input  logic [MASK_WIDTH-1:0]              master_a_mask,
  input  logic [DATA_WIDTH-1:0]              master_a_data,
  output logic                               master_d_valid,
  input  logic                               master_d_ready,
  output logic [OPCODE_WIDTH-1:0]            master_d_opcode,
  output logic [PARAM_WIDTH-1:0]             master_d_param,
  output logic [SIZE_WIDTH-1:0]              master_d_size,
  output logic [SOURCE_WIDTH-1:0]            master_d_source,
  output logic                               master_d_sink,
  output logic [DATA_WIDTH-1:0]              master_d_data,
  output logic                               master_d_error,
  output logic [NUM_SLAVES-1:0]              slave_a_valid,
  input  logic [NUM_SLAVES-1:0]              slave_a_ready,
  output logic [OPCODE_WIDTH-1:0]            slave_a_opcode,
  output logic [PARAM_WIDTH-1:0]             slave_a_param,
  output logic [SIZE_WIDTH-1:0]              slave_a_size,
  output logic [SOURCE_WIDTH-1:0]            slave_a_source,
  output logic [ADDR_WIDTH-1:0]              slave_a_address,
  output logic [MASK_WIDTH-1:0]              slave_a_mask,
  output logic [DATA_WIDTH-1:0]              slave_a_data,
  input  logic [NUM_SLAVES-1:0]              slave_d_valid,
  output logic [NUM_SLAVES-1:0]              slave_d_ready,
  input  logic [NUM_SLAVES*OPCODE_WIDTH-1:0] slave_d_opcode,
  input  logic [NUM_SLAVES*PARAM_WIDTH-1:0]  slave_d_param,
  input  logic [NUM_SLAVES*SIZE_WIDTH-1:0]   slave_d_size,
  input  logic [NUM_SLAVES*SOURCE_WIDTH-1:0] slave_d_source,
  input  logic [NUM_SLAVES-1:0]              slave_d_sink,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   slave_d_data,
  input  logic [NUM_SLAVES-1:0]              slave_d_error,
  output logic [7:0]                         err_count
);

  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1) + 1;
  // Counter value in the last permitted cycle of REQ+WAIT.
  localparam int TO_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [PARAM_WIDTH-1:0]  param;
    logic [SIZE_WIDTH-1:0]   size;
    logic [SOURCE_WIDTH-1:0] source;
    logic [ADDR_WIDTH-1:0]   address;
    logic [MASK_WIDTH-1:0]   mask;
    logic [DATA_WIDTH-1:0]   data;
  } a_req_t;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [PARAM_WIDTH-1:0]  param;
    logic [SIZE_WIDTH-1:0]   size;
    logic [SOURCE_WIDTH-1:0] source;
    logic                    sink;
    logic [DATA_WIDTH-1:0]   data;
    logic                    error;
  } d_rsp_t;

  function automatic d_rsp_t err_resp(input a_req_t a);
    d_rsp_t r;
    r        = '0;
    r.opcode = (a.opcode == OPCODE_WIDTH'(TL_GET)) ? OPCODE_WIDTH'(TL_ACCESS_ACK_DATA)
                                                   : OPCODE_WIDTH'(TL_ACCESS_ACK);
    r.size   = a.size;
    r.source = a.source;
    r.error  = 1'b1;
    return r;
  endfunction

  xbar_state_e           state;
  a_req_t                a_in, a_q;
  d_rsp_t                d_q, d_cap;
  logic [IDX_W-1:0]      sel, dec_idx;
  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic [CNT_W-1:0]      cnt, cnt_inc;
  logic                  timed_out;

  assign a_in = '{opcode: master_a_opcode, param: master_a_param, size: master_a_size,
                  source: master_a_source, address: master_a_address,
                  mask: master_a_mask, data: master_a_data};

  tlul_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W)
  ) u_dec (
    .addr       (master_a_address),
    .slave_base (SLAVE_BASE),
    .slave_mask (SLAVE_MASK),
    .hit        (dec_hit),
    .idx        (dec_idx)
  );

  // Selected slave's D payload out of the flattened buses.
  always_comb begin
    d_cap        = '0;
    d_cap.opcode = slave_d_opcode[sel*OPCODE_WIDTH +: OPCODE_WIDTH];
    d_cap.param  = slave_d_param[sel*PARAM_WIDTH +: PARAM_WIDTH];
    d_cap.size   = slave_d_size[sel*SIZE_WIDTH +: SIZE_WIDTH];
    d_cap.source = slave_d_source[sel*SOURCE_WIDTH +: SOURCE_WIDTH];
    d_cap.sink   = slave_d_sink[sel];
    d_cap.data   = slave_d_data[sel*DATA_WIDTH +: DATA_WIDTH];
    d_cap.error  = slave_d_error[sel];
  end

  assign sel_oh    = NUM_SLAVES'(1) << sel;
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
  // A response in the last permitted cycle still wins over the timeout.
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt >= CNT_W'(TO_LIM));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      d_q       <= '0;
      sel       <= '0;
      cnt       <= '0;
      err_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (master_a_valid) begin
            a_q <= a_in;
            cnt <= '0;
            if (dec_hit) begin
              sel   <= dec_idx;
              state <= ST_REQ;
            end else begin
              d_q       <= err_resp(a_in);
              err_count <= sat_inc8(err_count);
              state     <= ST_RESP;
            end
          end
        end
        ST_REQ: begin
          cnt <= cnt_inc;
          if (slave_a_ready[sel]) begin
            state <= ST_WAIT;
          end else if (timed_out) begin
            // Abandoning the request drops slave_a_valid without a handshake.
            d_q       <= err_resp(a_q);
            err_count <= sat_inc8(err_count);
            state     <= ST_RESP;
          end
        end
        ST_WAIT: begin
          cnt <= cnt_inc;
          if (slave_d_valid[sel]) begin
            d_q   <= d_cap;
            state <= ST_RESP;
          end else if (timed_out) begin
            d_q       <= err_resp(a_q);
            err_count <= sat_inc8(err_count);
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (master_d_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign master_a_ready  = (state == ST_IDLE);
  assign master_d_valid  = (state == ST_RESP);
  assign master_d_opcode = d_q.opcode;
  assign master_d_param  = d_q.param;
  assign master_d_size   = d_q.size;
  assign master_d_source = d_q.source;
  assign master_d_sink   = d_q.sink;
  assign master_d_data   = d_q.data;
  assign master_d_error  = d_q.error;

  assign slave_a_valid   = (state == ST_REQ) ? sel_oh : '0;
  // Idle accepts (and discards) anything, so late responses cannot wedge a slave.
  assign slave_d_ready   = (state == ST_IDLE) ? '1 :
                           (state == ST_WAIT) ? sel_oh : '0;
  assign slave_a_opcode  = a_q.opcode;
  assign slave_a_param   = a_q.param;
  assign slave_a_size    = a_q.size;
  assign slave_a_source  = a_q.source;
  assign slave_a_address = a_q.address;
  assign slave_a_mask    = a_q.mask;
  assign slave_a_data    = a_q.data;

endmodule

// File: tb/tb_tlul_xbar_1ton.sv
// Scoreboard bench for tlul_xbar_1ton: directed requests push expected D
// responses; a monitor pops and compares on each master D handshake.
module tb_tlul_xbar_1ton;

  localparam int NS = 4;
  localparam logic [NS*32-1:0] BASE = {32'h0000_4000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};
  localparam logic [NS*32-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_F000};

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [2:0]  size;
    logic        src;
    logic        sink;
    logic [31:0] data;
    logic        err;
  } d_t;

  logic clk, reset;
  logic master_a_valid, master_a_ready;
  logic [2:0] master_a_opcode, master_a_param, master_a_size;
  logic master_a_source;
  logic [31:0] master_a_address, master_a_data;
  logic [3:0] master_a_mask;
  logic master_d_valid, master_d_ready;
  logic [2:0] master_d_opcode, master_d_param, master_d_size;
  logic master_d_source, master_d_sink, master_d_error;
  logic [31:0] master_d_data;
  logic [NS-1:0] slave_a_valid, slave_a_ready, slave_d_valid, slave_d_ready;
  logic [2:0] slave_a_opcode, slave_a_param, slave_a_size;
  logic slave_a_source;
  logic [31:0] slave_a_address, slave_a_data;
  logic [3:0] slave_a_mask;
  logic [NS*3-1:0] slave_d_opcode, slave_d_param, slave_d_size;
  logic [NS-1:0] slave_d_source, slave_d_sink, slave_d_error;
  logic [NS*32-1:0] slave_d_data;
  logic [7:0] err_count;

  tlul_xbar_1ton #(
    .NUM_SLAVES(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .master_a_valid(master_a_valid), .master_a_ready(master_a_ready),
    .master_a_opcode(master_a_opcode), .master_a_param(master_a_param),
    .master_a_size(master_a_size), .master_a_source(master_a_source),
    .master_a_address(master_a_address), .master_a_mask(master_a_mask),
    .master_a_data(master_a_data),
    .master_d_valid(master_d_valid), .master_d_ready(master_d_ready),
    .master_d_opcode(master_d_opcode), .master_d_param(master_d_param),
    .master_d_size(master_d_size), .master_d_source(master_d_source),
    .master_d_sink(master_d_sink), .master_d_data(master_d_data),
    .master_d_error(master_d_error),
    .slave_a_valid(slave_a_valid), .slave_a_ready(slave_a_ready),
    .slave_a_opcode(slave_a_opcode), .slave_a_param(slave_a_param),
    .slave_a_size(slave_a_size), .slave_a_source(slave_a_source),
    .slave_a_address(slave_a_address), .slave_a_mask(slave_a_mask),
    .slave_a_data(slave_a_data),
    .slave_d_valid(slave_d_valid), .slave_d_ready(slave_d_ready),
    .slave_d_opcode(slave_d_opcode), .slave_d_param(slave_d_param),
    .slave_d_size(slave_d_size), .slave_d_source(slave_d_source),
    .slave_d_sink(slave_d_sink), .slave_d_data(slave_d_data),
    .slave_d_error(slave_d_error),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  d_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic d_t mk(input logic [2:0] op, input logic [2:0] sz, input logic src,
                            input logic [31:0] data, input logic err);
    d_t r;
    r.op = op; r.param = 3'd0; r.size = sz; r.src = src; r.sink = 1'b0;
    r.data = data; r.err = err;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- slave models ----------------
  logic [NS-1:0] s_aready, s_err, pend, a_hs, d_hs;
  int            s_lat[NS];
  logic [31:0]   s_data[NS];
  int            wcnt[NS];
  logic [2:0]    p_op[NS], p_size[NS];
  logic          p_src[NS];
  int            inj_req[NS], inj_done[NS];
  logic          rst_s;

  assign slave_a_ready = s_aready;

  initial begin
    slave_d_valid = '0; slave_d_opcode = '0; slave_d_param = '0; slave_d_size = '0;
    slave_d_source = '0; slave_d_sink = '0; slave_d_data = '0; slave_d_error = '0;
    pend = '0;
    for (int i = 0; i < NS; i++) begin wcnt[i] = 0; inj_done[i] = 0; end
    forever begin
      @(negedge clk);
      a_hs  = slave_a_valid & slave_a_ready;
      d_hs  = slave_d_valid & slave_d_ready;
      rst_s = reset;
      @(posedge clk); #1;
      for (int i = 0; i < NS; i++) begin
        if (rst_s) begin
          pend[i] = 1'b0; slave_d_valid[i] = 1'b0; inj_done[i] = inj_req[i];
        end else begin
          if (d_hs[i]) slave_d_valid[i] = 1'b0;
          if (a_hs[i]) begin
            pend[i] = 1'b1; wcnt[i] = s_lat[i];
            p_op[i] = slave_a_opcode; p_size[i] = slave_a_size; p_src[i] = slave_a_source;
          end
          if (inj_done[i] != inj_req[i]) begin
            // unsolicited response
            inj_done[i] = inj_req[i];
            slave_d_opcode[i*3 +: 3] = 3'd1; slave_d_param[i*3 +: 3] = 3'd0;
            slave_d_size[i*3 +: 3] = 3'd2; slave_d_source[i] = 1'b0; slave_d_sink[i] = 1'b0;
            slave_d_data[i*32 +: 32] = 32'hBAD0_0BAD; slave_d_error[i] = 1'b0;
            slave_d_valid[i] = 1'b1;
          end else if (pend[i]) begin
            if (wcnt[i] == 0) begin
              pend[i] = 1'b0;
              slave_d_opcode[i*3 +: 3] = (p_op[i] == 3'd4) ? 3'd1 : 3'd0;
              slave_d_param[i*3 +: 3] = 3'd0;
              slave_d_size[i*3 +: 3] = p_size[i];
              slave_d_source[i] = p_src[i];
              slave_d_sink[i] = 1'b0;
              slave_d_data[i*32 +: 32] = s_data[i];
              slave_d_error[i] = s_err[i];
              slave_d_valid[i] = 1'b1;
            end else begin
              wcnt[i] = wcnt[i] - 1;
            end
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    d_t act, e;
    logic [2:0] inv;
    forever begin
      @(negedge clk);
      if (!reset) begin
        inv = {master_a_ready & master_d_valid, !$onehot0(slave_a_valid),
               (slave_a_valid != '0) && ((slave_d_ready & ~slave_a_valid) != '0)};
        check("invariants", inv, 3'b000);
        if (master_d_valid && master_d_ready) begin
          act = {master_d_opcode, master_d_param, master_d_size, master_d_source,
                 master_d_sink, master_d_data, master_d_error};
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL d_unexpected: got %0h expected no response", act);
          end else begin
            e = exp_q.pop_front();
            check("d_response", act, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic src,
                      input logic [31:0] addr, input logic [31:0] wd, input d_t e,
                      output int t_acc);
    bit hit;
    hit = 1'b0;
    master_a_valid = 1'b1; master_a_opcode = op; master_a_param = 3'd0; master_a_size = sz;
    master_a_source = src; master_a_address = addr; master_a_mask = 4'hF; master_a_data = wd;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(negedge clk); hit = master_a_ready;
      @(posedge clk); #1;
    end
    master_a_valid = 1'b0;
    t_acc = cyc;
    if (!hit) begin
      checks++; errors++;
      $display("FAIL a_accept: got no master_a_ready expected accept within 40 cycles");
    end else begin
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !master_a_ready) && n < 40) begin tick(); n++; end
    check({name, "_drain"}, (n < 40), 1);
  endtask

  initial begin
    int t0, n;
    reset = 1'b1;
    master_a_valid = 0; master_a_opcode = 0; master_a_param = 0; master_a_size = 0;
    master_a_source = 0; master_a_address = 0; master_a_mask = 0; master_a_data = 0;
    master_d_ready = 1'b1;
    s_aready = 4'hF; s_err = 4'h0;
    for (int i = 0; i < NS; i++) begin s_lat[i] = 0; s_data[i] = 32'h0; inj_req[i] = 0; end

    tick();
    check("rst_a_ready", master_a_ready, 1);
    check("rst_d_valid", master_d_valid, 0);
    check("rst_s_a_valid", slave_a_valid, 4'h0);
    check("rst_s_d_ready", slave_d_ready, 4'hF);
    check("rst_err_count", err_count, 0);
    check("rst_d_data", master_d_data, 0);
    tick();
    reset = 1'b0;
    tick();

    // Get to slave 1
    s_data[1] = 32'hDEAD_BEEF;
    send(3'd4, 3'd2, 1'b1, 32'h0000_1004, 32'h0, mk(3'd1, 3'd2, 1'b1, 32'hDEAD_BEEF, 1'b0), t0);
    check("t1_sel", slave_a_valid, 4'b0010);
    check("t1_addr", slave_a_address, 32'h0000_1004);
    drain("t1");
    check("t1_turnaround", cyc - t0, 3);

    // unmapped PutFullData, then unmapped Get
    send(3'd0, 3'd2, 1'b0, 32'h9000_0000, 32'h1234_5678, mk(3'd0, 3'd2, 1'b0, 32'h0, 1'b1), t0);
    check("t2_d_next_cycle", master_d_valid, 1);
    check("t2_no_slave_a", slave_a_valid, 4'h0);
    drain("t2");
    check("t2_err_count", err_count, 1);
    send(3'd4, 3'd1, 1'b1, 32'hF000_0000, 32'h0, mk(3'd1, 3'd1, 1'b1, 32'h0, 1'b1), t0);
    check("t2b_no_slave_a", slave_a_valid, 4'h0);
    drain("t2b");
    check("t2b_err_count", err_count, 2);

    // overlap: 0x2008 hits slaves 0 and 2; slave 0 reports an error
    s_data[0] = 32'h0000_5150; s_err[0] = 1'b1; s_data[2] = 32'h2222_0002;
    send(3'd4, 3'd2, 1'b0, 32'h0000_2008, 32'h0, mk(3'd1, 3'd2, 1'b0, 32'h0000_5150, 1'b1), t0);
    check("t3_sel_lowest", slave_a_valid, 4'b0001);
    drain("t3");
    check("t3_slave_err_not_counted", err_count, 2);
    send(3'd0, 3'd2, 1'b0, 32'h0000_3000, 32'hAAAA_5555, mk(3'd0, 3'd2, 1'b0, 32'h2222_0002, 1'b0), t0);
    check("t3b_sel", slave_a_valid, 4'b0100);
    check("t3b_wdata", slave_a_data, 32'hAAAA_5555);
    drain("t3b");

    // timeout: slave 3 never accepts
    s_aready[3] = 1'b0;
    send(3'd1, 3'd0, 1'b1, 32'h0000_4000, 32'h0, mk(3'd0, 3'd0, 1'b1, 32'h0, 1'b1), t0);
    check("t4_sel", slave_a_valid, 4'b1000);
    n = 0;
    while (!master_d_valid && n < 30) begin tick(); n++; end
    check("t4_timeout_cycles", n, 8);
    check("t4_a_valid_dropped", slave_a_valid, 4'h0);
    drain("t4");
    check("t4_err_count", err_count, 3);
    inj_req[3] = inj_req[3] + 1;
    repeat (4) tick();
    check("t4_stray_absorbed", slave_d_valid[3], 0);
    check("t4_err_count_after", err_count, 3);
    s_aready[3] = 1'b1;

    // timeout boundary: response in cycle 8 served, cycle 9 too late
    s_lat[1] = 6; s_data[1] = 32'h1111_0008;
    send(3'd4, 3'd2, 1'b0, 32'h0000_1008, 32'h0, mk(3'd1, 3'd2, 1'b0, 32'h1111_0008, 1'b0), t0);
    drain("t5_in_time");
    check("t5_err_count", err_count, 3);
    s_lat[1] = 7;
    send(3'd4, 3'd2, 1'b0, 32'h0000_100C, 32'h0, mk(3'd1, 3'd2, 1'b0, 32'h0, 1'b1), t0);
    drain("t5_late");
    repeat (3) tick();
    check("t5_late_absorbed", slave_d_valid[1], 0);
    check("t5_err_count_late", err_count, 4);
    s_lat[1] = 0;

    // master stalls D for 5 cycles
    master_d_ready = 1'b0;
    s_data[1] = 32'hCAFE_0001;
    send(3'd4, 3'd2, 1'b1, 32'h0000_1020, 32'h0, mk(3'd1, 3'd2, 1'b1, 32'hCAFE_0001, 1'b0), t0);
    n = 0;
    while (!master_d_valid && n < 20) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      check("t6_d_valid_held", master_d_valid, 1);
      check("t6_d_data_stable", master_d_data, 32'hCAFE_0001);
      check("t6_a_ready_low", master_a_ready, 0);
      tick();
    end
    master_d_ready = 1'b1;
    drain("t6");

    // reset in WAIT, then a clean Get
    s_lat[1] = 5;
    send(3'd4, 3'd2, 1'b0, 32'h0000_1000, 32'h0, mk(3'd1, 3'd2, 1'b0, 32'h0, 1'b0), t0);
    tick();
    check("t7_in_wait", slave_d_ready, 4'b0010);
    reset = 1'b1;
    tick();
    check("t7_rst_d_valid", master_d_valid, 0);
    check("t7_rst_s_a_valid", slave_a_valid, 4'h0);
    check("t7_rst_s_d_ready", slave_d_ready, 4'hF);
    check("t7_rst_a_ready", master_a_ready, 1);
    check("t7_rst_err_count", err_count, 0);
    exp_q.delete();
    reset = 1'b0;
    repeat (2) tick();
    s_lat[1] = 0; s_data[1] = 32'h5A5A_A5A5;
    send(3'd4, 3'd2, 1'b1, 32'h0000_1000, 32'h0, mk(3'd1, 3'd2, 1'b1, 32'h5A5A_A5A5, 1'b0), t0);
    drain("t7_after");
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tlul_xbar_1ton.md
# tlul_xbar_1toN

Parametrised successor to the TL-UL single-slave crossbar path. Routes one TL-UL master to `NUM_SLAVES` slaves by address decode, one transaction in flight. Generates error responses locally for unmapped addresses and for slave timeouts. Sits in the 24 MHz domain between the main crossbar and the peripheral slaves, replacing the pass-through peripheral crossbar.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `MASK_WIDTH`, DATA_WIDTH/8, byte-mask width
- `SIZE_WIDTH`, 3, TL size field
- `OPCODE_WIDTH`, 3, TL opcode field
- `PARAM_WIDTH`, 3, TL param field
- `SOURCE_WIDTH`, 1, TL source field
- `NUM_SLAVES`, 4, slave ports, 1..16
- `SLAVE_BASE`, {NUM_SLAVES*ADDR_WIDTH}, flattened base addresses, slave i in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `SLAVE_MASK`, same layout, decode masks
- `TIMEOUT_CYCLES`, 255, response timeout; 0 disables

Ports:
- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high
- `master_a_valid`/`master_a_ready` in/out 1: A handshake
- `master_a_opcode`, `_param`, `_size`, `_source`, `_address`, `_mask`, `_data` in, field widths: A payload
- `master_d_valid` out 1 / `master_d_ready` in 1: D handshake
- `master_d_opcode`, `_param`, `_size`, `_source`, `_sink`(1), `_data`, `_error`(1) out: D payload
- `slave_a_valid` out NUM_SLAVES / `slave_a_ready` in NUM_SLAVES: per-slave A handshake
- `slave_a_opcode` … `slave_a_data` out, field widths: A payload broadcast to all slaves
- `slave_d_valid` in NUM_SLAVES / `slave_d_ready` out NUM_SLAVES
- `slave_d_opcode` … `slave_d_error` in, NUM_SLAVES×field widths: flattened per-slave D payload
- `err_count` out 8: saturating count of locally generated errors

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE
  - `master_a_ready`=1.
  - `slave_d_ready`=all ones; stray responses are discarded.
  - On A handshake: all A fields are registered and the address is decoded.
- Decode: slave i matches when (addr & MASK_i) == BASE_i. The lowest matching index wins.
  - Hit: latch `sel`, go to REQ.
  - No hit: build an error response, go to RESP.
- REQ: `slave_a_valid[sel]`=1, all other bits 0, payload held stable. On `slave_a_ready[sel]`, go to WAIT.
- WAIT: `slave_d_ready[sel]`=1, others 0. On `slave_d_valid[sel]`, capture that slave's D fields and go to RESP.
- RESP: `master_d_valid`=1 with the captured or error payload, held stable. On `master_d_ready`, go to IDLE.
- Error response fields:
  - opcode = AccessAckData (1) if the request was Get (4), otherwise AccessAck (0)
  - param=0, size and source echoed, sink=0, data=0, error=1
- Timeout:
  - A counter clears on entering REQ and increments each cycle in REQ and WAIT.
  - When it reaches TIMEOUT_CYCLES, `slave_a_valid` drops (fault recovery; this is a documented protocol break), the error response is built, and the FSM goes to RESP.
  - A late slave response is absorbed in IDLE.
- `err_count` increments on entry to RESP with error=1 and saturates at 255. Slave-reported errors are not counted.
- Reset: FSM to IDLE, counters 0. All outputs are 0 except `slave_d_ready`, which is all ones, and `master_a_ready`, which is 1 from the first cycle after reset.

## Timing
- A accept at cycle T → `slave_a_valid[sel]` at T+1.
- Slave D handshake at cycle U → `master_d_valid` at U+1.
- Unmapped request accepted at T → error response at T+1.
- Master D handshake at V → `master_a_ready`=1 at V+1. Back-to-back minimum: 4 cycles per transaction with zero-wait slaves.
- `master_a_ready` and `master_d_valid` are never high in the same cycle.
- At most one bit of `slave_a_valid` is high; `slave_a_valid` and `slave_d_ready` are never nonzero for different indices.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- Reset asserted mid-transaction: the next cycle is IDLE and any in-flight response is dropped.
- Timeout boundary: with TIMEOUT_CYCLES=N, a slave responding in exactly the N-th cycle of REQ+WAIT is served normally. Timeout fires only if no response has arrived after N cycles.

## Structure
- Shared package `tlul_pkg`:
  - opcode constants: Get=4, PutFullData=0, PutPartialData=1, AccessAck=0, AccessAckData=1
  - FSM state encoding
- Sub-module `tlul_addr_decode`: combinational; takes address, SLAVE_BASE and SLAVE_MASK; outputs hit and index, with lowest-index priority.

## Test plan
- Get to 0x0000_1004, slave 1 base 0x1000 mask 0xFFFF_F000, slave returns data 0xDEADBEEF → `slave_a_valid`=4'b0010, master D opcode 1, data 0xDEADBEEF, error 0.
- PutFullData to unmapped 0x9000_0000 → D at T+1 with opcode 0, error 1; `err_count`=1; no `slave_a_valid` bit ever asserted.
- Overlapping decode, slaves 0 and 2 both matching 0x2000 → only slave 0 is selected.
- TIMEOUT_CYCLES=8, slave never asserts `a_ready` → error response after 8 cycles; a late `slave_d_valid` in IDLE is dropped and the master sees no second response.
- Master holds `d_ready`=0 for 5 cycles → D payload stable and `master_a_ready`=0 throughout.
- Reset asserted in WAIT → all outputs at reset values the next cycle; a following Get completes normally.
